sb_handshake_tx_seq: RTL and testbench



---
 rtl/sb_ltsm_pkg.sv | 37 +++
 rtl/sb_timeout_cnt.sv | 34 +++
 rtl/sb_handshake_tx_seq.sv | 189 ++++++++++++++++++
 tb/tb_sb_handshake_tx_seq.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sb_ltsm_pkg.sv
// Shared LTSM sideband definitions: sequencer state encoding, sideband
// message codes and default timeout. Imported by the TX/RX handshake
// sequencers and their helpers.
package sb_ltsm_pkg;

    // Handshake sequencer states
    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StPattern  = 3'd1,
        StSend     = 3'd2,
        StWaitResp = 3'd3,
        StWaitIdle = 3'd4,
        StDone     = 3'd5,
        StError    = 3'd6
    } seq_state_e;

    // Encoded sideband message codes
    localparam int unsigned SbMsgW = 4;
    localparam logic [SbMsgW-1:0] MsgDoneReq           = 4'd1;
    localparam logic [SbMsgW-1:0] MsgDoneResp          = 4'd2;
    localparam logic [SbMsgW-1:0] MsgSbinitOutOfReset  = 4'd3;
    localparam logic [SbMsgW-1:0] MsgMbinitParamReq    = 4'd4;
    localparam logic [SbMsgW-1:0] MsgMbinitParamResp   = 4'd5;
    localparam logic [SbMsgW-1:0] MsgMbinitCalReq      = 4'd6;
    localparam logic [SbMsgW-1:0] MsgMbinitCalResp     = 4'd7;
    localparam logic [SbMsgW-1:0] MsgMbinitRepairReq   = 4'd8;
    localparam logic [SbMsgW-1:0] MsgMbinitRepairResp  = 4'd9;

    // 8 ms at 100 MHz
    localparam int unsigned DefTimeoutCycles = 800000;

    // States in which the whole-state timeout is running
    function automatic logic seq_counts(seq_state_e s);
        return (s == StPattern) || (s == StSend) || (s == StWaitResp) || (s == StWaitIdle);
    endfunction

endpackage

// File: rtl/sb_timeout_cnt.sv
// Saturating timeout counter with synchronous clear and terminal-count flag.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_en           : count this cycle
//   i_clr          : clear to zero (wins over i_en)
//   o_tc           : counter has reached TERMINAL (held while saturated)
module sb_timeout_cnt
    import sb_ltsm_pkg::*;
#(
    parameter int unsigned CNT_W    = 20,
    parameter int unsigned TERMINAL = DefTimeoutCycles - 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tc
);

    logic [CNT_W-1:0] cnt_q;

    assign o_tc = (cnt_q == CNT_W'(TERMINAL));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else if (i_clr) begin
            cnt_q <= '0;
        end else if (i_en && !o_tc) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sb_handshake_tx_seq.sv
// TX-side sideband handshake sequencer. Optionally requests the 64UI start
// pattern, then walks N_STEPS request/response exchanges with the partner,
// with optional per-step resend and a whole-state timeout.
// Ports:
//   i_clk, i_rst_n         : clock, asynchronous active-low reset
//   i_en                   : enable from LTSM; low aborts to IDLE
//   i_start_pattern_done   : SB finished sending the start pattern
//   i_req_msgs/i_resp_msgs : per-step request / expected response codes
//   i_repeat_mask          : per-step resend-until-response enable
//   i_rx_msg_valid, i_decoded_SB_msg : decoded partner message
//   i_sb_busy, i_falling_edge_busy, i_rx_valid : SB wrapper status
//   o_encoded_SB_msg_tx, o_valid_tx : message to the SB wrapper
//   o_start_pattern_req    : one-cycle start-pattern request
//   o_step, o_done, o_timeout : progress / completion / error
module sb_handshake_tx_seq
    import sb_ltsm_pkg::*;
#(
    parameter int unsigned SB_MSG_WIDTH   = 4,
    parameter int unsigned N_STEPS        = 2,
    parameter int unsigned PATTERN_EN     = 1,
    parameter int unsigned TIMEOUT_W      = 20,
    parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_en,
    input  logic                            i_start_pattern_done,
    input  logic [N_STEPS*SB_MSG_WIDTH-1:0] i_req_msgs,
    input  logic [N_STEPS*SB_MSG_WIDTH-1:0] i_resp_msgs,
    input  logic [N_STEPS-1:0]              i_repeat_mask,
    input  logic                            i_rx_msg_valid,
    input  logic [SB_MSG_WIDTH-1:0]         i_decoded_SB_msg,
    input  logic                            i_sb_busy,
    input  logic                            i_falling_edge_busy,
    input  logic                            i_rx_valid,
    output logic [SB_MSG_WIDTH-1:0]         o_encoded_SB_msg_tx,
    output logic                            o_valid_tx,
    output logic                            o_start_pattern_req,
    output logic [2:0]                      o_step,
    output logic                            o_done,
    output logic                            o_timeout
);

    seq_state_e              state_q;
    logic [2:0]              step_q;
    logic [SB_MSG_WIDTH-1:0] code_q;
    logic                    valid_q;
    logic                    pat_req_q;
    logic                    pat_issued_q;
    logic                    done_q;
    logic                    timeout_q;

    logic [SB_MSG_WIDTH-1:0] cur_req;
    logic [SB_MSG_WIDTH-1:0] cur_resp;
    logic                    cur_repeat;
    logic                    last_step;
    logic                    match;
    logic                    valid_clr;
    logic                    tc;

    // Select the current step's codes without a variable part-select
    always_comb begin
        cur_req    = '0;
        cur_resp   = '0;
        cur_repeat = 1'b0;
        for (int k = 0; k < N_STEPS; k++) begin
            if (step_q == 3'(k)) begin
                cur_req    = i_req_msgs[k*SB_MSG_WIDTH +: SB_MSG_WIDTH];
                cur_resp   = i_resp_msgs[k*SB_MSG_WIDTH +: SB_MSG_WIDTH];
                cur_repeat = i_repeat_mask[k];
            end
        end
    end

    assign last_step = (step_q == 3'(N_STEPS - 1));
    assign match     = i_rx_msg_valid && (i_decoded_SB_msg == cur_resp);
    // A falling busy edge only retires our message if RX was not the one on the bus
    assign valid_clr = i_falling_edge_busy && !i_rx_valid;

    sb_timeout_cnt #(
        .CNT_W    (TIMEOUT_W),
        .TERMINAL (TIMEOUT_CYCLES - 1)
    ) u_timeout_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (seq_counts(state_q)),
        .i_clr   (!i_en),
        .o_tc    (tc)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= StIdle;
            step_q       <= '0;
            code_q       <= '0;
            valid_q      <= 1'b0;
            pat_req_q    <= 1'b0;
            pat_issued_q <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else if (!i_en) begin
            state_q      <= StIdle;
            step_q       <= '0;
            code_q       <= '0;
            valid_q      <= 1'b0;
            pat_req_q    <= 1'b0;
            pat_issued_q <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else if (tc && seq_counts(state_q)) begin
            // Timeout beats any match seen in the same cycle
            state_q   <= StError;
            valid_q   <= 1'b0;
            pat_req_q <= 1'b0;
            timeout_q <= 1'b1;
        end else begin
            pat_req_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    step_q       <= '0;
                    pat_issued_q <= 1'b0;
                    if (PATTERN_EN != 0) begin
                        state_q <= StPattern;
                    end else begin
                        state_q <= StSend;
                    end
                end
                StPattern: begin
                    // Pulse once on the first PATTERN cycle only
                    pat_req_q    <= !pat_issued_q;
                    pat_issued_q <= 1'b1;
                    if (i_start_pattern_done) begin
                        state_q <= StSend;
                    end
                end
                StSend: begin
                    code_q  <= cur_req;
                    valid_q <= 1'b1;
                    state_q <= StWaitResp;
                end
                StWaitResp: begin
                    if (valid_clr) begin
                        valid_q <= 1'b0;
                    end else if (!match && cur_repeat && !valid_q && !i_sb_busy) begin
                        valid_q <= 1'b1;
                    end
                    if (match) begin
                        state_q <= StWaitIdle;
                    end
                end
                StWaitIdle: begin
                    if (valid_clr) begin
                        valid_q <= 1'b0;
                    end
                    if (!i_sb_busy) begin
                        if (last_step) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            step_q  <= step_q + 3'd1;
                            state_q <= StSend;
                        end
                    end
                end
                StDone: begin
                    done_q <= 1'b1;
                    if (valid_clr) begin
                        valid_q <= 1'b0;
                    end
                end
                StError: begin
                    timeout_q <= 1'b1;
                    valid_q   <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign o_encoded_SB_msg_tx = code_q;
    assign o_valid_tx          = valid_q;
    assign o_start_pattern_req = pat_req_q;
    assign o_step              = step_q;
    assign o_done              = done_q;
    assign o_timeout           = timeout_q;

endmodule

// File: tb/tb_sb_handshake_tx_seq.sv
// Directed bench for sb_handshake_tx_seq in the SBINIT configuration
// (step 0: send 3 / expect 3 with resend, step 1: send 1 / expect 2),
// with a short timeout so the timeout paths are reachable.
module tb_sb_handshake_tx_seq;

    localparam int unsigned W  = 4;
    localparam int unsigned NS = 2;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic          pattern_done;
    logic [NS*W-1:0] req_msgs;
    logic [NS*W-1:0] resp_msgs;
    logic [NS-1:0] repeat_mask;
    logic          rx_msg_valid;
    logic [W-1:0]  decoded;
    logic          sb_busy;
    logic          fe_busy;
    logic          rx_valid;
    logic [W-1:0]  code_tx;
    logic          valid_tx;
    logic          start_req;
    logic [2:0]    step;
    logic          done;
    logic          timeout;

    int n_tests = 0;
    int n_fail  = 0;

    sb_handshake_tx_seq #(
        .SB_MSG_WIDTH   (W),
        .N_STEPS        (NS),
        .PATTERN_EN     (1),
        .TIMEOUT_W      (8),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .i_clk                (clk),
        .i_rst_n              (rst_n),
        .i_en                 (en),
        .i_start_pattern_done (pattern_done),
        .i_req_msgs           (req_msgs),
        .i_resp_msgs          (resp_msgs),
        .i_repeat_mask        (repeat_mask),
        .i_rx_msg_valid       (rx_msg_valid),
        .i_decoded_SB_msg     (decoded),
        .i_sb_busy            (sb_busy),
        .i_falling_edge_busy  (fe_busy),
        .i_rx_valid           (rx_valid),
        .o_encoded_SB_msg_tx  (code_tx),
        .o_valid_tx           (valid_tx),
        .o_start_pattern_req  (start_req),
        .o_step               (step),
        .o_done               (done),
        .o_timeout            (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        en           = 1'b0;
        pattern_done = 1'b0;
        req_msgs     = {4'd1, 4'd3};
        resp_msgs    = {4'd2, 4'd3};
        repeat_mask  = 2'b01;
        rx_msg_valid = 1'b0;
        decoded      = '0;
        sb_busy      = 1'b0;
        fe_busy      = 1'b0;
        rx_valid     = 1'b0;

        #12;
        check("rst_valid", valid_tx, 0);
        check("rst_code", code_tx, 0);
        check("rst_pat", start_req, 0);
        check("rst_step", step, 0);
        check("rst_done", done, 0);
        check("rst_tmo", timeout, 0);
        rst_n = 1'b1;
        tick();

        // ---------------- SBINIT sequence ----------------
        en = 1'b1;
        tick();                                   // enter PATTERN
        check("pat_pre", start_req, 0);
        check("pat_valid0", valid_tx, 0);
        tick();
        check("pat_pulse", start_req, 1);
        tick();
        check("pat_once", start_req, 0);
        tick();
        tick();
        pattern_done = 1'b1;
        tick();                                   // enter SEND
        pattern_done = 1'b0;
        check("send_lat", valid_tx, 0);
        tick();
        check("s0_valid", valid_tx, 1);
        check("s0_code", code_tx, 3);
        check("s0_step", step, 0);

        // Partner silent: three send completions, three resends of code 3
        for (int i = 0; i < 3; i++) begin
            sb_busy = 1'b1;
            tick();
            sb_busy = 1'b0;
            fe_busy = 1'b1;
            tick();
            fe_busy = 1'b0;
            check("rep_clr", valid_tx, 0);
            tick();
            check("rep_valid", valid_tx, 1);
            check("rep_code", code_tx, 3);
            check("rep_step", step, 0);
        end

        // Non-matching message is ignored
        rx_msg_valid = 1'b1;
        decoded      = 4'd5;
        tick();
        rx_msg_valid = 1'b0;
        check("nm_step", step, 0);
        check("nm_valid", valid_tx, 1);
        // Falling edge while local RX drives SB does not retire our message
        rx_valid = 1'b1;
        fe_busy  = 1'b1;
        tick();
        rx_valid = 1'b0;
        check("rxv_hold", valid_tx, 1);
        check("nm_step2", step, 0);

        // Response 3 arrives with the send completion
        rx_msg_valid = 1'b1;
        decoded      = 4'd3;
        tick();
        rx_msg_valid = 1'b0;
        fe_busy      = 1'b0;
        check("m0_valid", valid_tx, 0);
        check("m0_step", step, 0);
        tick();
        check("adv_step", step, 1);
        check("adv_valid", valid_tx, 0);
        tick();
        check("s1_valid", valid_tx, 1);
        check("s1_code", code_tx, 1);
        check("s1_step", step, 1);
        sb_busy = 1'b1;
        tick();
        sb_busy = 1'b0;
        fe_busy = 1'b1;
        tick();
        fe_busy = 1'b0;
        check("s1_clr", valid_tx, 0);
        tick();
        check("s1_norep", valid_tx, 0);
        check("s1_step_h", step, 1);
        rx_msg_valid = 1'b1;
        decoded      = 4'd2;
        tick();
        rx_msg_valid = 1'b0;
        check("s1_notdone", done, 0);
        tick();
        check("done", done, 1);
        check("done_tmo", timeout, 0);
        tick();
        check("done_hold", done, 1);
        en = 1'b0;
        tick();
        check("dis_done", done, 0);
        check("dis_step", step, 0);

        // ---------------- Abort mid step 1 ----------------
        en = 1'b1;
        tick();
        tick();
        check("re_pat", start_req, 1);
        pattern_done = 1'b1;
        tick();
        pattern_done = 1'b0;
        tick();
        check("b_s0_valid", valid_tx, 1);
        check("b_s0_code", code_tx, 3);
        rx_msg_valid = 1'b1;
        decoded      = 4'd3;
        sb_busy      = 1'b1;
        tick();
        rx_msg_valid = 1'b0;
        sb_busy      = 1'b0;
        check("b_wi_step", step, 0);
        tick();
        check("b_adv", step, 1);
        tick();
        check("b_s1_valid", valid_tx, 1);
        check("b_s1_code", code_tx, 1);
        en = 1'b0;
        tick();
        check("ab_valid", valid_tx, 0);
        check("ab_code", code_tx, 0);
        check("ab_step", step, 0);
        check("ab_done", done, 0);
        check("ab_pat", start_req, 0);
        check("ab_tmo", timeout, 0);

        // ---------------- Timeout, partner silent ----------------
        en = 1'b1;
        tick();
        tick();
        pattern_done = 1'b1;
        tick();
        pattern_done = 1'b0;
        repeat (47) tick();                       // 50 edges after enable
        check("t_pre", timeout, 0);
        check("t_pre_valid", valid_tx, 1);
        tick();                                   // edge 51
        check("t_tmo", timeout, 1);
        check("t_valid", valid_tx, 0);
        check("t_done", done, 0);
        tick();
        check("t_hold", timeout, 1);
        en = 1'b0;
        tick();
        check("t_clr", timeout, 0);

        // ---------------- Match on terminal count ----------------
        en = 1'b1;
        tick();
        tick();
        pattern_done = 1'b1;
        tick();
        pattern_done = 1'b0;
        repeat (47) tick();
        check("mt_pre", timeout, 0);
        rx_msg_valid = 1'b1;
        decoded      = 4'd3;
        tick();
        rx_msg_valid = 1'b0;
        check("mt_tmo", timeout, 1);
        check("mt_done", done, 0);
        check("mt_step", step, 0);
        tick();
        tick();
        check("mt_done2", done, 0);
        check("mt_step2", step, 0);
        en = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
